// File: rtl/i2s_pkg.sv
// i2s_pkg: shared mode enum and default frame geometry for the I2S receive path
package i2s_pkg;
  typedef enum logic {I2S, TDM} i2s_mode_e;
  localparam int unsigned DEF_SLOT_BITS = 32;
  localparam int unsigned DEF_CHANNELS  = 2;
endpackage

// File: rtl/i2s_mod_cntr.sv
// i2s_mod_cntr: modulo-N counter with clear and terminal-count flag
module i2s_mod_cntr #(
  parameter int unsigned RES     = 5,
  parameter int unsigned MODULUS = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           clr_i,
  input  logic           en_i,
  output logic [RES-1:0] cnt_o,
  output logic           last_o
);
  localparam logic [RES-1:0] LAST = RES'(MODULUS - 1);
  logic [RES-1:0] cnt_q, cnt_d;
  assign cnt_o  = cnt_q;
  assign last_o = cnt_q == LAST;
  // clear beats enable; the terminal count wraps explicitly so non-power-of-two moduli work
  always_comb cnt_d = clr_i ? '0 : !en_i ? cnt_q : last_o ? '0 : cnt_q + 1'b1;
  // count register
  always_ff @(posedge clk_i)
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
endmodule

// File: rtl/i2s_frame_cntr.sv
// i2s_frame_cntr: bit/slot/frame position counter with word-select and frame strobe
module i2s_frame_cntr
  import i2s_pkg::*;
#(
  parameter int unsigned BIT_RES   = 5,
  parameter int unsigned SLOT_BITS = DEF_SLOT_BITS,
  parameter int unsigned CHANNELS  = DEF_CHANNELS,
  parameter int unsigned SLOT_RES  = 1,
  parameter int unsigned FRAME_RES = 16,
  parameter i2s_mode_e   MODE      = I2S
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 clr_i,
  output logic [BIT_RES-1:0]   bit_cnt_o,
  output logic [SLOT_RES-1:0]  slot_cnt_o,
  output logic [FRAME_RES-1:0] frame_cnt_o,
  output logic                 bit_last_o,
  output logic                 frame_last_o,
  output logic                 frame_stb_o,
  output logic                 ws_o
);
  if (SLOT_BITS < 2 || SLOT_BITS > 2 ** BIT_RES) begin : g_bad_bits
    $error("SLOT_BITS out of range for BIT_RES");
  end
  if (CHANNELS < 1 || CHANNELS > 2 ** SLOT_RES) begin : g_bad_slots
    $error("CHANNELS out of range for SLOT_RES");
  end
  if (MODE == I2S && CHANNELS % 2 != 0) begin : g_bad_i2s
    $error("I2S mode needs an even channel count");
  end
  logic                 slot_last, wrap, ws_i2s;
  logic [FRAME_RES-1:0] frame_q, frame_d;
  logic                 stb_q;
  i2s_mod_cntr #(.RES(BIT_RES), .MODULUS(SLOT_BITS)) u_bit (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .en_i(en_i),
    .cnt_o(bit_cnt_o), .last_o(bit_last_o)
  );
  i2s_mod_cntr #(.RES(SLOT_RES), .MODULUS(CHANNELS)) u_slot (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .en_i(en_i & bit_last_o),
    .cnt_o(slot_cnt_o), .last_o(slot_last)
  );
  assign frame_last_o = bit_last_o & slot_last;
  assign wrap         = en_i & frame_last_o & ~clr_i;
  assign frame_cnt_o  = frame_q;
  assign frame_stb_o  = stb_q;
  // word select reflects the slot parity one bit ahead; even channel counts make the wrap to slot 0 a parity flip too
  assign ws_i2s = bit_last_o ? (slot_last ? 1'b0 : ~slot_cnt_o[0]) : slot_cnt_o[0];
  assign ws_o   = (MODE == TDM) ? frame_last_o : ws_i2s;
  // frame counter advances on each frame wrap and is deliberately left to overflow
  always_comb frame_d = wrap ? frame_q + 1'b1 : frame_q;
  // frame count and strobe registers; clear keeps the frame count
  always_ff @(posedge clk_i)
    if (rst_i) begin
      frame_q <= '0;
      stb_q   <= 1'b0;
    end else begin
      frame_q <= frame_d;
      stb_q   <= wrap;
    end
endmodule

// File: tb/tb_i2s_frame_cntr.sv
// tb_i2s_frame_cntr: randomized check of three geometries against a position-based model
module tb_i2s_frame_cntr;
  import i2s_pkg::*;
  localparam int SB[3] = '{32, 24, 3};
  localparam int CH[3] = '{2, 4, 2};
  localparam int FR[3] = '{16, 16, 2};
  localparam bit TD[3] = '{1'b0, 1'b1, 1'b0};
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, clr = 1'b0;
  bit run = 1'b0;
  int vec = 0, bad = 0;
  logic [4:0] b0, b1;
  logic [1:0] b2, s1, f2;
  logic s0, s2;
  logic [15:0] f0, f1;
  logic [2:0] bl, fl, st, ws;
  int ob[3], os[3], of[3];
  int pos[3] = '{0, 0, 0};
  int frm[3] = '{0, 0, 0};
  int mstb[3] = '{0, 0, 0};
  always #5 clk = ~clk;
  i2s_frame_cntr u0 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr),
    .bit_cnt_o(b0), .slot_cnt_o(s0), .frame_cnt_o(f0),
    .bit_last_o(bl[0]), .frame_last_o(fl[0]), .frame_stb_o(st[0]), .ws_o(ws[0])
  );
  i2s_frame_cntr #(.BIT_RES(5), .SLOT_BITS(24), .CHANNELS(4), .SLOT_RES(2), .FRAME_RES(16), .MODE(TDM)) u1 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr),
    .bit_cnt_o(b1), .slot_cnt_o(s1), .frame_cnt_o(f1),
    .bit_last_o(bl[1]), .frame_last_o(fl[1]), .frame_stb_o(st[1]), .ws_o(ws[1])
  );
  i2s_frame_cntr #(.BIT_RES(2), .SLOT_BITS(3), .CHANNELS(2), .SLOT_RES(1), .FRAME_RES(2), .MODE(I2S)) u2 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr),
    .bit_cnt_o(b2), .slot_cnt_o(s2), .frame_cnt_o(f2),
    .bit_last_o(bl[2]), .frame_last_o(fl[2]), .frame_stb_o(st[2]), .ws_o(ws[2])
  );
  always_comb begin
    ob[0] = int'(b0); ob[1] = int'(b1); ob[2] = int'(b2);
    os[0] = int'(s0); os[1] = int'(s1); os[2] = int'(s2);
    of[0] = int'(f0); of[1] = int'(f1); of[2] = int'(f2);
  end
  task automatic chk(input string nm, input int a, input int e);
    vec++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got %0d want %0d", nm, a, e);
    end
  endtask
  task automatic step(input logic e, input logic c, input logic r);
    en = e; clr = c; rst = r;
    @(posedge clk);
    #1;
  endtask
  // model: position within the frame counts enables; everything else is derived arithmetically
  always @(posedge clk)
    for (int k = 0; k < 3; k++) begin
      int n;
      n = SB[k] * CH[k];
      if (rst) begin
        pos[k] = 0; frm[k] = 0; mstb[k] = 0;
      end else if (clr) begin
        pos[k] = 0; mstb[k] = 0;
      end else begin
        mstb[k] = (en && pos[k] == n - 1) ? 1 : 0;
        if (en) begin
          if (pos[k] == n - 1) begin
            pos[k] = 0;
            frm[k] = (frm[k] + 1) % (1 << FR[k]);
          end else pos[k] = pos[k] + 1;
        end
      end
    end
  always @(negedge clk)
    if (run)
      for (int k = 0; k < 3; k++) begin
        int n, nxt;
        n = SB[k] * CH[k];
        nxt = (pos[k] + 1) % n;
        chk($sformatf("bit%0d", k), ob[k], pos[k] % SB[k]);
        chk($sformatf("slot%0d", k), os[k], pos[k] / SB[k]);
        chk($sformatf("frame%0d", k), of[k], frm[k]);
        chk($sformatf("bit_last%0d", k), int'(bl[k]), int'(pos[k] % SB[k] == SB[k] - 1));
        chk($sformatf("frame_last%0d", k), int'(fl[k]), int'(pos[k] == n - 1));
        chk($sformatf("stb%0d", k), int'(st[k]), mstb[k]);
        chk($sformatf("ws%0d", k), int'(ws[k]), TD[k] ? int'(pos[k] == n - 1) : (nxt / SB[k]) % 2);
      end
  initial begin
    int n0, n2, nw1, cnt;
    step(0, 0, 1);
    step(0, 0, 1);
    run = 1'b1;
    chk("rst_bit", ob[0], 0);
    chk("rst_frame", of[0], 0);
    chk("rst_ws", int'(ws[0]), 0);
    chk("rst_stb", int'(st[0]), 0);
    n0 = 0; n2 = 0; nw1 = 0;
    for (int i = 1; i <= 96; i++) begin
      step(1, 0, 0);
      n0 += int'(st[0]); n2 += int'(st[2]); nw1 += int'(ws[1]);
      if (i == 24) begin
        chk("wrap_frame", of[2], 0);
        chk("wrap_stb_count", n2, 4);
      end
      if (i == 31) begin
        chk("ws_rise_bit", ob[0], 31);
        chk("ws_rise", int'(ws[0]), 1);
      end
      if (i == 63) chk("ws_fall", int'(ws[0]), 0);
      if (i == 64) begin
        chk("f64_frame", of[0], 1);
        chk("f64_bit", ob[0], 0);
        chk("f64_slot", os[0], 0);
        chk("f64_stb_count", n0, 1);
      end
    end
    chk("tdm_ws_count", nw1, 1);
    step(0, 0, 1);
    cnt = 0;
    while (cnt < 200) begin
      logic e;
      e = 1'($urandom_range(0, 1));
      step(e, 0, 0);
      cnt += int'(e);
    end
    chk("gap_bit", ob[0], 8);
    chk("gap_slot", os[0], 0);
    chk("gap_frame", of[0], 3);
    step(0, 0, 1);
    repeat (362) step(1, 0, 0);
    chk("pre_clr_bit", ob[0], 10);
    chk("pre_clr_slot", os[0], 1);
    chk("pre_clr_frame", of[0], 5);
    step(1, 1, 0);
    chk("clr_bit", ob[0], 0);
    chk("clr_slot", os[0], 0);
    chk("clr_frame", of[0], 5);
    chk("clr_stb", int'(st[0]), 0);
    repeat (63) step(1, 0, 0);
    step(1, 1, 0);
    chk("clr_at_last_stb", int'(st[0]), 0);
    chk("clr_at_last_frame", of[0], 5);
    repeat (5) step(1, 0, 0);
    step(1, 1, 1);
    chk("rst_clr_frame", of[0], 0);
    repeat (4000)
      step(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 199) == 0), logic'($urandom_range(0, 999) == 0));
    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
